// File: rtl/sha_pkg.sv
// Shared definitions for the SHA-256 datapath: initial hash values, default widths
// and the byte serializer state encoding.
package sha_pkg;

  localparam int HASH_W_DEF = 256;
  localparam int BYTE_W_DEF = 8;

  // H0..H7 initial hash values, H0 in the top word.
  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } hbs_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector. A level already high when reset is released
// reports a rise on the first cycle because the history register resets to 0.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/hash_byte_serializer.sv
// Captures a digest on the rising edge of hash_rdy and streams it out one byte per
// accepted valid/ready transfer, flagging digests that arrive while still draining.
module hash_byte_serializer
  import sha_pkg::*;
#(
  parameter int HASH_W    = HASH_W_DEF,
  parameter int BYTE_W    = BYTE_W_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hash_rdy,
  input  logic [HASH_W-1:0] HASH,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              ovf,
  output logic [1:0]        dbg_state
);

  localparam int N_BYTES = HASH_W / BYTE_W;
  localparam int CNT_W   = $clog2(N_BYTES);

  // Handshake: a byte transfers on a posedge where out_valid & out_ready are both
  // high; while out_valid is high and out_ready low, out_data/out_last/out_valid hold.

  hbs_state_t        state_q, state_d;
  logic [HASH_W-1:0] sr_q;
  logic [HASH_W-1:0] cap;
  logic [CNT_W-1:0]  cnt_q;
  logic              valid_q;
  logic              ovf_q;
  logic              rise;
  logic              accept;
  logic              at_last;
  logic              load_en;
  logic              shift_en;
  logic              overrun;

  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (hash_rdy),
    .rise (rise)
  );

  // The shift register always emits from its top byte, so LSB-first order is
  // obtained by byte-reversing the digest at capture time.
  always_comb begin
    cap = HASH;
    if (!MSB_FIRST) begin
      for (int i = 0; i < N_BYTES; i++) begin
        cap[i*BYTE_W +: BYTE_W] = HASH[(N_BYTES-1-i)*BYTE_W +: BYTE_W];
      end
    end
  end

  assign accept  = valid_q & out_ready;
  assign at_last = (cnt_q == CNT_W'(N_BYTES - 1));
  assign overrun = rise & (state_q != IDLE) & ~flush;

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    shift_en = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (rise) begin
          state_d = LOAD;
          load_en = 1'b1;
        end
        LOAD: state_d = SEND;
        SEND: if (accept) begin
          shift_en = 1'b1;
          if (at_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_d == SEND);
      if (flush || load_en) cnt_q <= '0;
      else if (shift_en)    cnt_q <= cnt_q + CNT_W'(1);
      if (load_en)       sr_q <= cap;
      else if (shift_en) sr_q <= sr_q << BYTE_W;
    end
  end

  // A fresh overrun beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ovf_q <= 1'b0;
    else if (overrun) ovf_q <= 1'b1;
    else if (clr_ovf) ovf_q <= 1'b0;
  end

  assign out_data  = sr_q[HASH_W-1 -: BYTE_W];
  assign out_valid = valid_q;
  assign out_last  = valid_q & at_last;
  assign busy      = (state_q != IDLE);
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hash_byte_serializer.sv
// Directed bench for hash_byte_serializer: an MSB-first instance covers the main
// behaviours and an LSB-first instance covers the byte-order variant.
module tb_hash_byte_serializer;

  localparam logic [255:0] HASH_A =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] HASH_B = {32{8'hAA}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         hash_rdy = 1'b0;
  logic [255:0] hash_in = '0;
  logic         flush = 1'b0;
  logic         clr_ovf = 1'b0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         busy;
  logic         ovf;
  logic [1:0]   dbg_state;

  logic         hash_rdy2 = 1'b0;
  logic [7:0]   out_data2;
  logic         out_valid2;
  logic         out_ready2 = 1'b1;
  logic         out_last2;
  logic         busy2;
  logic         ovf2;
  logic [1:0]   dbg_state2;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  hash_byte_serializer #(.HASH_W(256), .BYTE_W(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .hash_rdy(hash_rdy), .HASH(hash_in), .flush(flush),
    .clr_ovf(clr_ovf), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .ovf(ovf), .dbg_state(dbg_state)
  );

  hash_byte_serializer #(.HASH_W(256), .BYTE_W(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .hash_rdy(hash_rdy2), .HASH(HASH_A), .flush(1'b0),
    .clr_ovf(1'b0), .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_last(out_last2), .busy(busy2), .ovf(ovf2), .dbg_state(dbg_state2)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(8'(i));
  endtask

  // Accept n bytes, checking every presented byte against the head of exp_q.
  task automatic drain(input bit rand_ready, input int n, input int budget, input string tag);
    int acc = 0;
    int cyc = 0;
    bit started = 1'b0;
    while (acc < n && cyc < budget) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid) started = 1'b1;
      if (started) begin
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, 32'(out_data), 32'(exp_q[0]));
        chk({tag, "_last"}, 32'(out_last), 32'(exp_q.size() == 1));
        if (out_valid && out_ready) begin
          void'(exp_q.pop_front());
          acc++;
        end
      end
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    chk({tag, "_count"}, 32'(acc), 32'(n));
  endtask

  initial begin
    int stray;

    // reset values
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    tick();

    // reset in the middle of a stream
    hash_in = HASH_A;
    fill();
    hash_rdy = 1'b1;
    drain(1'b0, 3, 10, "pre_rst");
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_last", 32'(out_last), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    hash_rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_valid", 32'(out_valid), 32'd0);

    // basic stream with latency check
    fill();
    hash_rdy = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("lat_load_busy", 32'(busy), 32'd1);
    chk("lat_load_valid", 32'(out_valid), 32'd0);
    tick();
    chk("lat_first_valid", 32'(out_valid), 32'd1);
    chk("lat_first_data", 32'(out_data), 32'h00);
    drain(1'b0, 32, 40, "basic");
    chk("basic_end_busy", 32'(busy), 32'd0);
    chk("basic_end_valid", 32'(out_valid), 32'd0);
    hash_rdy = 1'b0;
    tick();

    // random backpressure
    fill();
    hash_rdy = 1'b1;
    drain(1'b1, 32, 600, "bp");
    hash_rdy = 1'b0;
    tick();
    chk("bp_end_busy", 32'(busy), 32'd0);

    // overrun at byte 10
    fill();
    hash_rdy = 1'b1;
    tick();
    hash_rdy = 1'b0;
    drain(1'b0, 10, 20, "ovr_a");
    chk("ovr_pre_ovf", 32'(ovf), 32'd0);
    hash_in = HASH_B;
    hash_rdy = 1'b1;
    tick();
    chk("ovr_set", 32'(ovf), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    hash_rdy = 1'b0;
    drain(1'b0, 22, 40, "ovr_b");
    chk("ovr_sticky", 32'(ovf), 32'd1);
    chk("ovr_end_busy", 32'(busy), 32'd0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovr_clr", 32'(ovf), 32'd0);
    hash_in = HASH_A;

    // rise coincident with acceptance of the last byte, clear in the same cycle
    fill();
    hash_rdy = 1'b1;
    tick();
    hash_rdy = 1'b0;
    drain(1'b0, 31, 40, "coin");
    chk("coin_last_data", 32'(out_data), 32'h1F);
    chk("coin_last_flag", 32'(out_last), 32'd1);
    out_ready = 1'b1;
    hash_rdy = 1'b1;
    clr_ovf = 1'b1;
    tick();
    out_ready = 1'b0;
    clr_ovf = 1'b0;
    chk("coin_ovf", 32'(ovf), 32'd1);
    chk("coin_busy", 32'(busy), 32'd0);
    chk("coin_valid", 32'(out_valid), 32'd0);
    hash_rdy = 1'b0;
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("coin_clr", 32'(ovf), 32'd0);

    // level held high well past one stream
    fill();
    hash_rdy = 1'b1;
    drain(1'b0, 32, 40, "held");
    stray = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 70; i++) begin
      if (out_valid || busy) stray++;
      tick();
    end
    out_ready = 1'b0;
    chk("held_stray", 32'(stray), 32'd0);
    chk("held_ovf", 32'(ovf), 32'd0);
    hash_rdy = 1'b0;
    tick();

    // flush at byte 5, then restart from byte 0
    fill();
    hash_rdy = 1'b1;
    tick();
    hash_rdy = 1'b0;
    drain(1'b0, 5, 20, "fl_a");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_ovf", 32'(ovf), 32'd0);
    fill();
    hash_rdy = 1'b1;
    tick();
    hash_rdy = 1'b0;
    drain(1'b0, 32, 40, "fl_b");

    // a rise during flush is swallowed
    flush = 1'b1;
    hash_rdy = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_rise_busy0", 32'(busy), 32'd0);
    tick();
    chk("flush_rise_busy1", 32'(busy), 32'd0);
    hash_rdy = 1'b0;
    tick();

    // LSB-first instance
    hash_rdy2 = 1'b1;
    tick();
    tick();
    chk("lsb_valid", 32'(out_valid2), 32'd1);
    chk("lsb_byte0", 32'(out_data2), 32'h1F);
    tick();
    chk("lsb_byte1", 32'(out_data2), 32'h1E);
    tick();
    chk("lsb_byte2", 32'(out_data2), 32'h1D);
    hash_rdy2 = 1'b0;
    for (int i = 0; i < 40 && busy2; i++) tick();
    chk("lsb_end_busy", 32'(busy2), 32'd0);
    chk("lsb_end_state", 32'(dbg_state2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
